// File: rtl/datapath_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_pkg
// Shared definitions for the RV64I datapath control FSM:
//   - opcode / funct3 / funct7 constants for the supported subset
//   - controller state encoding
//   - instruction-class encoding plus a decode helper
// No ports (package).
// -----------------------------------------------------------------------------
package datapath_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_D     = 3'b011;

    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ADD  = 3'd0,
        C_SUB  = 3'd1,
        C_ADDI = 3'd2,
        C_LD   = 3'd3,
        C_SD   = 3'd4,
        C_ILL  = 3'd5
    } iclass_t;

    // Classify a raw instruction word; anything outside the subset is C_ILL.
    function automatic iclass_t decode_class(input logic [31:0] w);
        iclass_t c;
        c = C_ILL;
        case (w[6:0])
            OP_RTYPE: begin
                if (w[14:12] == F3_ADD && w[31:25] == F7_ADD)      c = C_ADD;
                else if (w[14:12] == F3_ADD && w[31:25] == F7_SUB) c = C_SUB;
            end
            OP_ITYPE: if (w[14:12] == F3_ADD) c = C_ADDI;
            OP_LOAD:  if (w[14:12] == F3_D)   c = C_LD;
            OP_STORE: if (w[14:12] == F3_D)   c = C_SD;
            default:  c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_ctrl_fsm_imm_gen.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_fsm_imm_gen (imm_gen)
// Combinational immediate generator: picks the I- or S-type immediate field
// according to the instruction class and sign-extends it from bit 11 to XLEN.
// Ports:
//   instr   in  32    instruction word
//   iclass  in  3     instruction class (datapath_ctrl_pkg::iclass_t encoding)
//   imm     out XLEN  sign-extended immediate (0 for R-type / illegal)
// -----------------------------------------------------------------------------
module imm_gen
    import datapath_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      iclass,
    output logic [XLEN-1:0] imm
);

    // Opcode and the middle fields play no part in the immediate.
    logic unused_bits;
    assign unused_bits = ^{instr[19:12], instr[6:0]};

    always_comb begin
        imm = '0;
        case (iclass)
            C_ADDI, C_LD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            C_SD:         imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            default:      imm = '0;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_fsm
// Multi-cycle controller for the 64-bit load/store/add datapath. Accepts one
// RV64I word per valid/ready handshake, decodes ADD/SUB/ADDI/LD/SD and sequences
// IDLE -> DECODE -> EXEC -> {MEM} -> {WB} -> IDLE. Every output is a flop whose
// next value is computed together with the next state.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr instruction handshake
//   done, illegal                 1-cycle completion / rejection pulses
//   immediate                     sign-extended immediate (XLEN)
//   readRegister1/2, writeRegister  rs1 / rs2 / rd fields
//   writeEnable_Registers, writeEnable_DataMemory  write strobes
//   muxSelect_SumVsReadData, muxSelect_ImmVsDataout2, SumOrSub  datapath controls
// Optional (macro DATAPATH_CTRL_PERF_EN):
//   retired_cnt[31:0], illegal_cnt[15:0]  wrapping event counters
// -----------------------------------------------------------------------------
module datapath_ctrl_fsm
    import datapath_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            done,
    output logic            illegal,
    output logic [XLEN-1:0] immediate,
    output logic [4:0]      readRegister1,
    output logic [4:0]      readRegister2,
    output logic [4:0]      writeRegister,
    output logic            writeEnable_Registers,
    output logic            writeEnable_DataMemory,
    output logic            muxSelect_SumVsReadData,
    output logic            muxSelect_ImmVsDataout2,
    output logic            SumOrSub
`ifdef DATAPATH_CTRL_PERF_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [15:0]     illegal_cnt
`endif
);

    state_t            state_q, state_d;
    iclass_t           cls_q, cls_d, dec_cls;
    logic [31:0]       instr_q, instr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d, done_q, done_d, illegal_q, illegal_d;
    logic              we_rf_q, we_rf_d, we_dm_q, we_dm_d;
    logic              sel_sum_q, sel_sum_d, sel_imm_q, sel_imm_d, sub_q, sub_d;
    logic [XLEN-1:0]   imm_q, imm_d, imm_dec;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic              go_idle;

    assign dec_cls = decode_class(instr_q);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr  (instr_q),
        .iclass (dec_cls),
        .imm    (imm_dec)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        we_rf_d   = 1'b0;
        we_dm_d   = 1'b0;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        sel_sum_d = sel_sum_q;
        sel_imm_d = sel_imm_q;
        sub_d     = sub_q;
        go_idle   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                    ready_d = 1'b0;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_ILL) begin
                    illegal_d = 1'b1;
                    go_idle   = 1'b1;
                end else begin
                    state_d   = S_EXEC;
                    imm_d     = imm_dec;
                    rs1_d     = instr_q[19:15];
                    rs2_d     = instr_q[24:20];
                    rd_d      = instr_q[11:7];
                    sub_d     = (dec_cls == C_SUB);
                    sel_imm_d = (dec_cls == C_ADDI) || (dec_cls == C_LD) || (dec_cls == C_SD);
                    sel_sum_d = (dec_cls == C_ADD) || (dec_cls == C_SUB) || (dec_cls == C_ADDI);
                end
            end
            S_EXEC: begin
                if (cls_q == C_LD || cls_q == C_SD) begin
                    state_d = S_MEM;
                    cnt_d   = 4'(MEM_LAT - 1);
                    // The store strobe lands in the last MEM cycle, which is
                    // also the first one when MEM_LAT is 1.
                    we_dm_d = (cls_q == C_SD) && (cnt_d == 4'd0);
                end else begin
                    state_d = S_WB;
                    we_rf_d = (rd_q != 5'd0);
                end
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    if (cls_q == C_SD) begin
                        done_d  = 1'b1;
                        go_idle = 1'b1;
                    end else begin
                        state_d = S_WB;
                        we_rf_d = (rd_q != 5'd0);
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    we_dm_d = (cls_q == C_SD) && (cnt_d == 4'd0);
                end
            end
            S_WB: begin
                done_d  = 1'b1;
                go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase

        // Returning to IDLE clears the datapath controls to their reset values.
        if (go_idle) begin
            state_d   = S_IDLE;
            ready_d   = 1'b1;
            imm_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            sel_sum_d = 1'b0;
            sel_imm_d = 1'b0;
            sub_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ADD;
            instr_q   <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            we_rf_q   <= 1'b0;
            we_dm_q   <= 1'b0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            sel_sum_q <= 1'b0;
            sel_imm_q <= 1'b0;
            sub_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            we_rf_q   <= we_rf_d;
            we_dm_q   <= we_dm_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            sel_sum_q <= sel_sum_d;
            sel_imm_q <= sel_imm_d;
            sub_q     <= sub_d;
        end
    end

    assign instr_ready             = ready_q;
    assign done                    = done_q;
    assign illegal                 = illegal_q;
    assign immediate               = imm_q;
    assign readRegister1           = rs1_q;
    assign readRegister2           = rs2_q;
    assign writeRegister           = rd_q;
    assign writeEnable_Registers   = we_rf_q;
    assign writeEnable_DataMemory  = we_dm_q;
    assign muxSelect_SumVsReadData = sel_sum_q;
    assign muxSelect_ImmVsDataout2 = sel_imm_q;
    assign SumOrSub                = sub_q;

`ifdef DATAPATH_CTRL_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    // Counters step on the same edge that raises the pulse; wrap is natural.
    always_comb begin
        retired_cnt_d = retired_cnt_q + {31'd0, done_d};
        illegal_cnt_d = illegal_cnt_q + {15'd0, illegal_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl_fsm
// Self-checking bench for datapath_ctrl_fsm (MEM_LAT=3): hand-computed vector
// table, reset-in-MEM sequence, and random instructions checked against a
// cycle-timeline reference model. Optional counters checked when
// DATAPATH_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl_fsm;

    localparam int XLEN = 64;
    localparam int LAT  = 3;

    logic            clk;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic            done;
    logic            illegal;
    logic [XLEN-1:0] immediate;
    logic [4:0]      rr1, rr2, wr;
    logic            we_rf, we_dm, sel_sum, sel_imm, sum_or_sub;
`ifdef DATAPATH_CTRL_PERF_EN
    logic [31:0]     retired_cnt;
    logic [15:0]     illegal_cnt;
`endif

    datapath_ctrl_fsm #(.XLEN(XLEN), .MEM_LAT(LAT)) u_dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .instr_valid             (instr_valid),
        .instr_ready             (instr_ready),
        .instr                   (instr),
        .done                    (done),
        .illegal                 (illegal),
        .immediate               (immediate),
        .readRegister1           (rr1),
        .readRegister2           (rr2),
        .writeRegister           (wr),
        .writeEnable_Registers   (we_rf),
        .writeEnable_DataMemory  (we_dm),
        .muxSelect_SumVsReadData (sel_sum),
        .muxSelect_ImmVsDataout2 (sel_imm),
        .SumOrSub                (sum_or_sub)
`ifdef DATAPATH_CTRL_PERF_EN
        ,
        .retired_cnt             (retired_cnt),
        .illegal_cnt             (illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_instr = '0;
    int exp_retired = 0;
    int exp_illegal = 0;

    typedef struct {
        logic [31:0] instr;
        int          n;         // cycle in which done/illegal is high
        int          wreg_cyc;  // cycle with register write strobe (0 = none)
        int          wdm_cyc;   // cycle with memory write strobe (0 = none)
        logic        ill;
        logic [63:0] imm;
        logic        imm_sel;
        logic        sub;
        logic        sum_sel;
        logic        chk_sum;   // SD leaves SumVsReadData unconstrained
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s instr=%h actual=%h required=%h", name, cur_instr, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] w, input int n, input int wr_c, input int wd_c,
                                input logic ill, input logic [63:0] imm, input logic isel,
                                input logic sub, input logic ssel, input logic cs);
        vec_t v;
        v.instr = w; v.n = n; v.wreg_cyc = wr_c; v.wdm_cyc = wd_c; v.ill = ill;
        v.imm = imm; v.imm_sel = isel; v.sub = sub; v.sum_sel = ssel; v.chk_sum = cs;
        return v;
    endfunction

    // Reference model: expected timeline from the instruction fields and latency rules.
    function automatic vec_t model(input logic [31:0] w, input int k);
        vec_t   v;
        int     op, f3, f7, rd;
        longint s;
        op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]); rd = int'(w[11:7]);
        v = mk(w, 2, 0, 0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (op == 51 && f3 == 0 && (f7 == 0 || f7 == 32)) begin
            v = mk(w, 4, (rd != 0) ? 3 : 0, 0, 1'b0, 64'd0, 1'b0, f7 == 32, 1'b1, 1'b1);
        end else if ((op == 19 && f3 == 0) || (op == 3 && f3 == 3)) begin
            s = longint'(w[31:20]);
            if (s >= 2048) s = s - 4096;
            if (op == 19) v = mk(w, 4, (rd != 0) ? 3 : 0, 0, 1'b0, 64'(s), 1'b1, 1'b0, 1'b1, 1'b1);
            else          v = mk(w, 4 + k, (rd != 0) ? 3 + k : 0, 0, 1'b0, 64'(s), 1'b1, 1'b0, 1'b0, 1'b1);
        end else if (op == 35 && f3 == 3) begin
            s = longint'(w[31:25]) * 32 + longint'(w[11:7]);
            if (s >= 2048) s = s - 4096;
            v = mk(w, 3 + k, 0, 2 + k, 1'b0, 64'(s), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        return v;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".ready"},   64'(instr_ready), 64'd1);
        chk({tag, ".done"},    64'(done),        64'd0);
        chk({tag, ".illegal"}, 64'(illegal),     64'd0);
        chk({tag, ".we_rf"},   64'(we_rf),       64'd0);
        chk({tag, ".we_dm"},   64'(we_dm),       64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run(input vec_t v, input bit hold);
        cur_instr = v.instr;
        chk("ready_pre", 64'(instr_ready), 64'd1);
        instr_valid = 1'b1;
        instr       = v.instr;
        @(posedge clk);
        for (int c = 1; c <= v.n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) instr = 32'h002081B3;
                else      instr_valid = 1'b0;
            end
            chk("ready",   64'(instr_ready), 64'(c == v.n));
            chk("done",    64'(done),        64'(c == v.n && !v.ill));
            chk("illegal", 64'(illegal),     64'(c == v.n && v.ill));
            chk("we_rf",   64'(we_rf),       64'(c == v.wreg_cyc));
            chk("we_dm",   64'(we_dm),       64'(c == v.wdm_cyc));
            if (c >= 2 && c <= v.n - 1) begin
                chk("imm",     immediate,        v.imm);
                chk("imm_sel", 64'(sel_imm),     64'(v.imm_sel));
                chk("sub",     64'(sum_or_sub),  64'(v.sub));
                if (v.chk_sum) chk("sum_sel", 64'(sel_sum), 64'(v.sum_sel));
                chk("rs1", 64'(rr1), 64'(v.instr[19:15]));
                chk("rs2", 64'(rr2), 64'(v.instr[24:20]));
                chk("rd",  64'(wr),  64'(v.instr[11:7]));
            end
            if (c == v.n) instr_valid = 1'b0;
        end
        if (v.ill) exp_illegal++;
        else       exp_retired++;
        $display("txn instr=%h ill=%0d n=%0d hold=%0d checks=%0d errors=%0d",
                 v.instr, v.ill, v.n, hold, checks, errors);
    endtask

    vec_t tbl[12];

    initial begin
        vec_t        v;
        logic [31:0] w;
        int          r;

        tbl[0]  = mk(32'hFFD00293, 4, 3, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[1]  = mk(32'h406283B3, 4, 3, 0, 1'b0, 64'd0,                  1'b0, 1'b1, 1'b1, 1'b1);
        tbl[2]  = mk(32'h00513823, 6, 0, 5, 1'b0, 64'd16,                 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(32'h01013403, 7, 6, 0, 1'b0, 64'd16,                 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[4]  = mk(32'h00208033, 4, 0, 0, 1'b0, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1);
        tbl[5]  = mk(32'h0000000F, 2, 0, 0, 1'b1, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(32'h002081B3, 4, 3, 0, 1'b0, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b1);
        tbl[7]  = mk(32'h7FF00093, 4, 3, 0, 1'b0, 64'h0000_0000_0000_07FF, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[8]  = mk(32'h80000093, 4, 3, 0, 1'b0, 64'hFFFF_FFFF_FFFF_F800, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[9]  = mk(32'hFE513C23, 6, 0, 5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(32'h022081B3, 2, 0, 0, 1'b1, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(32'h01012403, 2, 0, 0, 1'b1, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        repeat (2) @(negedge clk);
        chk_quiet("rst");
        chk("rst.imm", immediate, 64'd0);
        chk("rst.sel", 64'({sel_sum, sel_imm, sum_or_sub, rr1, rr2, wr}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");

        // Table: back-to-back, FENCE entry holds instr_valid while busy
        for (int i = 0; i < 12; i++) run(tbl[i], i == 5);
        @(negedge clk);
        chk_quiet("gap");

        // Reset while SD sits in its strobe cycle of MEM
        cur_instr = 32'h00513823;
        instr_valid = 1'b1; instr = 32'h00513823;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
        chk("rstmem.we_dm_before", 64'(we_dm), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmem.we_dm_async", 64'(we_dm), 64'd0);
        chk("rstmem.ready_async", 64'(instr_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 0; exp_illegal = 0;
        @(negedge clk);
        chk_quiet("rstmem.after");
        chk("rstmem.imm", immediate, 64'd0);
        $display("txn reset-in-MEM sequence checks=%0d errors=%0d", checks, errors);
        run(tbl[0], 1'b0);

        // Random instructions against the reference model
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            r = $urandom_range(0, 6);
            case (r)
                0: w = {($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000, w[24:15], 3'b000, w[11:7], 7'b0110011};
                1: w = {w[31:15], 3'b000, w[11:7], 7'b0010011};
                2: w = {w[31:15], 3'b011, w[11:7], 7'b0000011};
                3: w = {w[31:15], 3'b011, w[11:7], 7'b0100011};
                4: w = {w[31:7], 7'b0110011};
                5: w = {w[31:15], 3'($urandom_range(0, 7)), w[11:7], 7'b0000011};
                default: ;
            endcase
            v = model(w, LAT);
            run(v, $urandom_range(0, 1) != 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk_quiet("idle");
            end
        end

`ifdef DATAPATH_CTRL_PERF_EN
        chk("retired_cnt", 64'(retired_cnt), 64'(exp_retired));
        chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_illegal));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
